icd_bus_engine: RTL

Parametrised ICD command engine sitting between the ICD SPI-slave byte stream (USB/FTDI port) and the NORA internal bus master port. It decodes a header byte plus data bytes into GETSTATUS, BUS/MEM burst access and CPU CTRL operations. Address width is configurable, each bus request is bounded by a watchdog, and sticky error flags can be read back. It is the successor to the fixed 24-bit ICD controller and adds status, CPU control, timeout and overrun handling.

---
 rtl/icd_bus_engine.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/icd_bus_engine.sv
// ---------------------------------------------------------------------------
// icd_bus_engine
//
// ICD command engine between the SPI-slave byte stream (USB/FTDI side) and
// the NORA internal bus master port. A header byte selects the command and
// the data bytes that follow drive it:
//   cmd 0  GETSTATUS : every data byte is answered with the status byte
//                      {5'b0, overrun, timeout, cpu_stop}; hdr[7] clears the
//                      sticky flags after the first reply.
//   cmd 1  BUS/MEM   : ADDR_BYTES address bytes (LSB first, echoed), then a
//                      burst of reads (dummy bytes) or writes (data bytes).
//                      hdr[4] selects OTHER over SRAM, hdr[5] selects read,
//                      hdr[6] enables address post-increment.
//   cmd 2  CPU CTRL  : the first data byte drives stop/step/reset; the reply
//                      is the status byte from before the update.
//   other            : ignored until the next header.
// Every bus request is bounded by a TIMEOUT_CYC watchdog.
//
// Parameters
//   ADDR_BYTES   address bytes per BUS/MEM command (ADDR_W = 8*ADDR_BYTES)
//   TIMEOUT_CYC  clk6x cycles a request may wait for ack (1..65535)
//
// Ports
//   clk6x, resetn              48 MHz clock, synchronous active-low reset
//   rx_byte_i                  received byte
//   rx_hdr_en_i / rx_db_en_i   pulses: rx_byte_i is a header / data byte
//   tx_byte_o / tx_en_o        byte to transmit, one-cycle valid pulse
//   nora_mst_addr_o            bus address
//   nora_mst_data_o            write data
//   nora_mst_datard_i          read data, valid with ack
//   nora_mst_ack_i             access complete pulse
//   nora_mst_req_SRAM_o        request level towards SRAM
//   nora_mst_req_OTHER_o       request level towards other targets
//   nora_mst_rwn_o             1 = read, 0 = write
//   cpu_stop_o                 CPU halt level
//   cpu_step_o                 one-cycle single-step pulse
//   cpu_reset_o                CPU reset level
// ---------------------------------------------------------------------------
module icd_bus_engine #(
  parameter int ADDR_BYTES  = 3,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                    clk6x,
  input  logic                    resetn,
  input  logic [7:0]              rx_byte_i,
  input  logic                    rx_hdr_en_i,
  input  logic                    rx_db_en_i,
  output logic [7:0]              tx_byte_o,
  output logic                    tx_en_o,
  output logic [8*ADDR_BYTES-1:0] nora_mst_addr_o,
  output logic [7:0]              nora_mst_data_o,
  input  logic [7:0]              nora_mst_datard_i,
  input  logic                    nora_mst_ack_i,
  output logic                    nora_mst_req_SRAM_o,
  output logic                    nora_mst_req_OTHER_o,
  output logic                    nora_mst_rwn_o,
  output logic                    cpu_stop_o,
  output logic                    cpu_step_o,
  output logic                    cpu_reset_o
);

  localparam int          ADDR_W   = 8 * ADDR_BYTES;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  CNT_LAST = 8'(ADDR_BYTES - 1);

  localparam logic [3:0] CMD_STAT = 4'h0;
  localparam logic [3:0] CMD_BUS  = 4'h1;
  localparam logic [3:0] CMD_CPU  = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PEND,
    S_CPU,
    S_STAT,
    S_IGN
  } state_t;

  state_t              state_q, state_d;
  // Upper header nibble: {clear, increment, read, other}
  logic [3:0]          hdr_q, hdr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                req_sram_q, req_sram_d;
  logic                req_oth_q, req_oth_d;
  logic                rwn_q, rwn_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic                ovr_q, ovr_d;
  logic                tmo_q, tmo_d;
  logic                stop_q, stop_d;
  logic                step_q, step_d;
  logic                rst_q, rst_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_en_q, tx_en_d;

  logic [7:0]          status;
  logic [ADDR_W-1:0]   addr_shift;
  logic                pend_done;

  assign status = {5'b0, ovr_q, tmo_q, stop_q};

  // Address bytes arrive LSB first: each new byte enters at the top and the
  // register shifts down, so after ADDR_BYTES bytes the first one is at [7:0].
  assign addr_shift = (addr_q >> 8) | (ADDR_W'(rx_byte_i) << (ADDR_W - 8));

  // Ack has priority over a simultaneous watchdog expiry.
  assign pend_done = nora_mst_ack_i || (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    req_sram_d = req_sram_q;
    req_oth_d  = req_oth_q;
    rwn_d      = rwn_q;
    tmo_cnt_d  = tmo_cnt_q;
    ovr_d      = ovr_q;
    tmo_d      = tmo_q;
    stop_d     = stop_q;
    step_d     = 1'b0;
    rst_d      = rst_q;
    tx_byte_d  = tx_byte_q;
    tx_en_d    = 1'b0;

    if (rx_hdr_en_i) begin
      // A header always restarts the engine and abandons any open request;
      // a late ack then lands in a state that does not look at it.
      hdr_d      = rx_byte_i[7:4];
      cnt_d      = '0;
      req_sram_d = 1'b0;
      req_oth_d  = 1'b0;
      unique case (rx_byte_i[3:0])
        CMD_STAT: state_d = S_STAT;
        CMD_BUS:  state_d = S_ADDR;
        CMD_CPU:  state_d = S_CPU;
        default:  state_d = S_IGN;
      endcase
    end else begin
      unique case (state_q)
        S_STAT: begin
          if (rx_db_en_i) begin
            tx_byte_d = status;
            tx_en_d   = 1'b1;
            if (hdr_q[3] && (cnt_q == '0)) begin
              ovr_d = 1'b0;
              tmo_d = 1'b0;
            end
            cnt_d = 8'd1;
          end
        end

        S_ADDR: begin
          if (rx_db_en_i) begin
            addr_d    = addr_shift;
            tx_byte_d = rx_byte_i;
            tx_en_d   = 1'b1;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
              if (hdr_q[1]) begin
                req_sram_d = ~hdr_q[0];
                req_oth_d  = hdr_q[0];
                rwn_d      = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = S_PEND;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          // Reads use the byte only as a trigger; writes also latch it.
          if (rx_db_en_i) begin
            if (!hdr_q[1]) begin
              data_d = rx_byte_i;
            end
            req_sram_d = ~hdr_q[0];
            req_oth_d  = hdr_q[0];
            rwn_d      = hdr_q[1];
            tmo_cnt_d  = '0;
            state_d    = S_PEND;
          end
        end

        S_PEND: begin
          // The host outran the bus: the byte is lost, remember that.
          if (rx_db_en_i) begin
            ovr_d = 1'b1;
          end
          if (pend_done) begin
            req_sram_d = 1'b0;
            req_oth_d  = 1'b0;
            if (rwn_q) begin
              tx_byte_d = nora_mst_ack_i ? nora_mst_datard_i : 8'hFF;
              tx_en_d   = 1'b1;
            end
            if (!nora_mst_ack_i) begin
              tmo_d = 1'b1;
            end
            if (hdr_q[2]) begin
              addr_d = addr_q + ADDR_W'(1);
            end
            state_d = S_DATA;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end

        S_CPU: begin
          // Only the first byte after the header acts; the reply reports
          // the state the host is about to change.
          if (rx_db_en_i && (cnt_q == '0)) begin
            tx_byte_d = status;
            tx_en_d   = 1'b1;
            stop_d    = rx_byte_i[0];
            rst_d     = rx_byte_i[2];
            step_d    = rx_byte_i[1] & rx_byte_i[0];
            cnt_d     = 8'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      req_sram_q <= 1'b0;
      req_oth_q  <= 1'b0;
      rwn_q      <= 1'b1;
      tmo_cnt_q  <= '0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      stop_q     <= 1'b0;
      step_q     <= 1'b0;
      rst_q      <= 1'b0;
      tx_byte_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      req_sram_q <= req_sram_d;
      req_oth_q  <= req_oth_d;
      rwn_q      <= rwn_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      rst_q      <= rst_d;
      tx_byte_q  <= tx_byte_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign tx_byte_o            = tx_byte_q;
  assign tx_en_o              = tx_en_q;
  assign nora_mst_addr_o      = addr_q;
  assign nora_mst_data_o      = data_q;
  assign nora_mst_req_SRAM_o  = req_sram_q;
  assign nora_mst_req_OTHER_o = req_oth_q;
  assign nora_mst_rwn_o       = rwn_q;
  assign cpu_stop_o           = stop_q;
  assign cpu_step_o           = step_q;
  assign cpu_reset_o          = rst_q;

endmodule
